reset_manager: RTL and testbench
================================

RESET_MANAGER -- requirements
Module: reset_manager

Interface
REQ-001 Parameter RST_PULSE_LEN, default 8: cycles sys_rst/factory_rst stay asserted per event; legal range 1..255.
REQ-002 Parameter FACTORY_HOLD, default 20000: further consecutive cycles botao_rst must stay high after the soft reset to trigger a factory reset; legal range 1..65535.
REQ-003 clk  input  1  system clock, all logic on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 rst_db  input  1  single-cycle debounced reset-request pulse from the reset debouncer.
REQ-006 botao_rst  input  1  raw reset-button level, already synchronous to clk.
REQ-007 sys_rst  output  1  synchronous reset pulse to the lock datapath/FSM.
REQ-008 factory_rst  output  1  pulse restoring the default password.
REQ-009 busy  output  1  high whenever state is not IDLE.
REQ-010 rst_count  output  8  saturating count of accepted soft resets.

Function
REQ-011 States SHALL be IDLE, SOFT, HOLD, FACT, WAIT_REL; all outputs registered.
REQ-012 IDLE: rst_db=1 -> SOFT; otherwise stay.
REQ-013 sys_rst SHALL rise the cycle after rst_db is sampled high in IDLE and stay high exactly RST_PULSE_LEN cycles (SOFT duration).
REQ-014 rst_count SHALL increment by 1 on each IDLE->SOFT transition, saturating at 255.
REQ-015 End of SOFT: botao_rst=0 -> IDLE; botao_rst=1 -> HOLD (factory feature in) or WAIT_REL (feature out).
REQ-016 HOLD: count cycles with botao_rst=1 starting at 0 on entry; botao_rst=0 at any HOLD cycle -> IDLE, no factory reset.
REQ-017 HOLD: after FACTORY_HOLD consecutive cycles with botao_rst=1 -> FACT.
REQ-018 FACT: factory_rst and sys_rst both high exactly RST_PULSE_LEN cycles, then -> WAIT_REL.
REQ-019 WAIT_REL: stay while botao_rst=1; botao_rst=0 -> IDLE.
REQ-020 rst_db pulses arriving in any state other than IDLE SHALL be ignored (no restart, no count).
REQ-021 rst_db=1 in the same cycle IDLE is re-entered SHALL NOT start a new event; it is accepted only while in IDLE.
REQ-022 Counter widths SHALL be $clog2-sized from parameters; no counter wraps.
REQ-023 factory_rst SHALL never be high unless sys_rst is high in the same cycle.

Reset
REQ-024 rst high SHALL immediately force state IDLE, sys_rst=0, factory_rst=0, busy=0, rst_count=0, all internal counters 0, including mid-SOFT/HOLD/FACT.
REQ-025 After rst deasserts, first rst_db SHALL be honoured from the next rising edge.

Configuration
REQ-026 Macro RESET_MGR_FACTORY_EN defined: HOLD and FACT states and hold counter compiled in per REQ-015..REQ-018.
REQ-027 Macro undefined: HOLD/FACT logic absent, factory_rst tied 0, SOFT ends to IDLE or WAIT_REL only; FACTORY_HOLD ignored.

Verification (RST_PULSE_LEN=4, FACTORY_HOLD=10 unless noted)
REQ-028 rst_db pulse at cycle 0, botao_rst=0 -> sys_rst high cycles 1..4, busy low at cycle 5, rst_count=1, factory_rst never high.
REQ-029 rst_db at 0, botao_rst held high 20 cycles (macro defined) -> sys_rst 1..4, HOLD 5..14, factory_rst+sys_rst 15..18, WAIT_REL until botao_rst falls, then IDLE.
REQ-030 Same as REQ-029 but botao_rst falls at cycle 9 -> IDLE at 10, factory_rst never high, rst_count=1.
REQ-031 Second rst_db pulse at cycle 2 during SOFT -> ignored, sys_rst still ends after cycle 4, rst_count=1.
REQ-032 rst asserted at cycle 3 of FACT -> all outputs 0 and rst_count=0 immediately, asynchronously.
REQ-033 Macro undefined, botao_rst held 20 cycles -> sys_rst 1..4, WAIT_REL until release, factory_rst always 0; 300 accepted events -> rst_count=255.

Source files
------------

// File: rtl/reset_manager.sv
// reset_manager: turns debounced reset requests into timed soft/factory reset pulses
// Ports:
//   clk          system clock, all logic on rising edge
//   rst          asynchronous active-high reset
//   rst_db       single-cycle debounced reset-request pulse
//   botao_rst    raw reset-button level, synchronous to clk
//   sys_rst      reset pulse to the lock datapath/FSM
//   factory_rst  pulse restoring the default password (always with sys_rst)
//   busy         high whenever the manager is not idle
//   rst_count    saturating count of accepted soft resets
// Define RESET_MGR_FACTORY_EN to compile in the hold-to-factory-reset feature.
module reset_manager #(
    parameter int RST_PULSE_LEN = 8,
    parameter int FACTORY_HOLD  = 20000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rst_db,
    input  logic       botao_rst,
    output logic       sys_rst,
    output logic       factory_rst,
    output logic       busy,
    output logic [7:0] rst_count
);
    localparam int PW = $clog2(RST_PULSE_LEN + 1);
    localparam logic [PW-1:0] P_LAST = PW'(RST_PULSE_LEN - 1);
    typedef enum logic [2:0] {IDLE, SOFT, HOLD, FACT, WAIT_REL} state_t;
    state_t state;
    logic [PW-1:0] pcnt;
`ifdef RESET_MGR_FACTORY_EN
    localparam int HW = $clog2(FACTORY_HOLD + 1);
    localparam logic [HW-1:0] H_LAST = HW'(FACTORY_HOLD - 1);
    logic [HW-1:0] hcnt;
`else
    logic unused_hold;
    assign unused_hold = (FACTORY_HOLD == 0);
    assign factory_rst = 1'b0;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pcnt      <= '0;
            sys_rst   <= 1'b0;
            busy      <= 1'b0;
            rst_count <= '0;
`ifdef RESET_MGR_FACTORY_EN
            factory_rst <= 1'b0;
            hcnt        <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (rst_db) begin
                    state     <= SOFT;
                    sys_rst   <= 1'b1;
                    busy      <= 1'b1;
                    pcnt      <= '0;
                    rst_count <= rst_count + {7'd0, rst_count != 8'hff};
                end
                SOFT: if (pcnt == P_LAST) begin
                    sys_rst <= 1'b0;
                    pcnt    <= '0;
                    if (botao_rst) begin
`ifdef RESET_MGR_FACTORY_EN
                        state <= HOLD;
                        hcnt  <= '0;
`else
                        state <= WAIT_REL;
`endif
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end else begin
                    pcnt <= pcnt + PW'(1);
                end
`ifdef RESET_MGR_FACTORY_EN
                HOLD: if (!botao_rst) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    hcnt  <= '0;
                end else if (hcnt == H_LAST) begin
                    state       <= FACT;
                    sys_rst     <= 1'b1;
                    factory_rst <= 1'b1;
                    pcnt        <= '0;
                    hcnt        <= '0;
                end else begin
                    hcnt <= hcnt + HW'(1);
                end
                FACT: if (pcnt == P_LAST) begin
                    state       <= WAIT_REL;
                    sys_rst     <= 1'b0;
                    factory_rst <= 1'b0;
                    pcnt        <= '0;
                end else begin
                    pcnt <= pcnt + PW'(1);
                end
`endif
                WAIT_REL: if (!botao_rst) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    sys_rst <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_reset_manager.sv
// tb_reset_manager: directed self-checking bench for reset_manager (RST_PULSE_LEN=4, FACTORY_HOLD=10)
module tb_reset_manager;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rst_db = 1'b0;
    logic       botao_rst = 1'b0;
    logic       sys_rst, factory_rst, busy;
    logic [7:0] rst_count;
    int tests = 0;
    int failed = 0;
    int exp_cnt = 0;
    always #5 clk = ~clk;
    reset_manager #(.RST_PULSE_LEN(4), .FACTORY_HOLD(10)) dut (
        .clk(clk), .rst(rst), .rst_db(rst_db), .botao_rst(botao_rst),
        .sys_rst(sys_rst), .factory_rst(factory_rst), .busy(busy), .rst_count(rst_count)
    );
    task automatic step;
        @(posedge clk);
        #1;
    endtask
    task automatic test_reset;
        rst = 1'b1;
        step;
        step;
        tests++;
        if ({sys_rst, factory_rst, busy, rst_count} !== 11'd0) begin
            failed++;
            $display("FAIL reset_state got %b exp %b", {sys_rst, factory_rst, busy, rst_count}, 11'd0);
        end
        rst = 1'b0;
        rst_db = 1'b1;
        step;
        rst_db = 1'b0;
        exp_cnt = 1;
        tests++;
        if ({sys_rst, busy} !== 2'b11) begin
            failed++;
            $display("FAIL first_db_after_reset got %b exp 11", {sys_rst, busy});
        end
        repeat (5) step;
        tests++;
        if ({busy, rst_count} !== {1'b0, 8'(exp_cnt)}) begin
            failed++;
            $display("FAIL first_event_done got %b exp %b", {busy, rst_count}, {1'b0, 8'(exp_cnt)});
        end
    endtask
    task automatic test_soft;
        logic [2:0] e;
        botao_rst = 1'b0;
        rst_db = 1'b1;
        exp_cnt++;
        for (int c = 1; c <= 6; c++) begin
            step;
            rst_db = 1'b0;
            e = (c <= 4) ? 3'b101 : 3'b000;
            tests++;
            if ({sys_rst, factory_rst, busy} !== e) begin
                failed++;
                $display("FAIL soft cyc %0d got %b exp %b", c, {sys_rst, factory_rst, busy}, e);
            end
        end
        tests++;
        if (rst_count !== 8'(exp_cnt)) begin
            failed++;
            $display("FAIL soft_count got %0d exp %0d", rst_count, exp_cnt);
        end
    endtask
    task automatic test_ignore;
        logic [2:0] e;
        rst_db = 1'b1;
        exp_cnt++;
        for (int c = 1; c <= 6; c++) begin
            step;
            rst_db = (c == 2);
            e = (c <= 4) ? 3'b101 : 3'b000;
            tests++;
            if ({sys_rst, factory_rst, busy} !== e) begin
                failed++;
                $display("FAIL ignore cyc %0d got %b exp %b", c, {sys_rst, factory_rst, busy}, e);
            end
        end
        tests++;
        if (rst_count !== 8'(exp_cnt)) begin
            failed++;
            $display("FAIL ignore_count got %0d exp %0d", rst_count, exp_cnt);
        end
    endtask
    task automatic test_back_to_back;
        logic [2:0] e;
        rst_db = 1'b1;
        exp_cnt += 2;
        for (int c = 1; c <= 10; c++) begin
            step;
            rst_db = (c == 4 || c == 5);
            e = ((c >= 1 && c <= 4) || (c >= 6 && c <= 9)) ? 3'b101 : 3'b000;
            tests++;
            if ({sys_rst, factory_rst, busy} !== e) begin
                failed++;
                $display("FAIL back_to_back cyc %0d got %b exp %b", c, {sys_rst, factory_rst, busy}, e);
            end
        end
        tests++;
        if (rst_count !== 8'(exp_cnt)) begin
            failed++;
            $display("FAIL back_to_back_count got %0d exp %0d", rst_count, exp_cnt);
        end
    endtask
`ifdef RESET_MGR_FACTORY_EN
    task automatic test_factory;
        logic [2:0] e;
        botao_rst = 1'b1;
        rst_db = 1'b1;
        exp_cnt++;
        for (int c = 1; c <= 22; c++) begin
            step;
            rst_db = 1'b0;
            botao_rst = (c < 20);
            e = (c <= 4) ? 3'b101 : (c <= 14) ? 3'b001 : (c <= 18) ? 3'b111 : (c <= 20) ? 3'b001 : 3'b000;
            tests++;
            if ({sys_rst, factory_rst, busy} !== e) begin
                failed++;
                $display("FAIL factory cyc %0d got %b exp %b", c, {sys_rst, factory_rst, busy}, e);
            end
        end
        tests++;
        if (rst_count !== 8'(exp_cnt)) begin
            failed++;
            $display("FAIL factory_count got %0d exp %0d", rst_count, exp_cnt);
        end
    endtask
    task automatic test_hold_abort;
        logic [2:0] e;
        botao_rst = 1'b1;
        rst_db = 1'b1;
        exp_cnt++;
        for (int c = 1; c <= 12; c++) begin
            step;
            rst_db = 1'b0;
            botao_rst = (c < 9);
            e = (c <= 4) ? 3'b101 : (c <= 9) ? 3'b001 : 3'b000;
            tests++;
            if ({sys_rst, factory_rst, busy} !== e) begin
                failed++;
                $display("FAIL hold_abort cyc %0d got %b exp %b", c, {sys_rst, factory_rst, busy}, e);
            end
        end
        tests++;
        if (rst_count !== 8'(exp_cnt)) begin
            failed++;
            $display("FAIL hold_abort_count got %0d exp %0d", rst_count, exp_cnt);
        end
    endtask
`else
    task automatic test_no_factory;
        logic [2:0] e;
        botao_rst = 1'b1;
        rst_db = 1'b1;
        exp_cnt++;
        for (int c = 1; c <= 22; c++) begin
            step;
            rst_db = 1'b0;
            botao_rst = (c < 20);
            e = (c <= 4) ? 3'b101 : (c <= 20) ? 3'b001 : 3'b000;
            tests++;
            if ({sys_rst, factory_rst, busy} !== e) begin
                failed++;
                $display("FAIL no_factory cyc %0d got %b exp %b", c, {sys_rst, factory_rst, busy}, e);
            end
        end
        tests++;
        if (rst_count !== 8'(exp_cnt)) begin
            failed++;
            $display("FAIL no_factory_count got %0d exp %0d", rst_count, exp_cnt);
        end
    endtask
`endif
    task automatic test_async_reset;
        logic [2:0] e;
        int target;
`ifdef RESET_MGR_FACTORY_EN
        target = 17;
        e = 3'b111;
`else
        target = 3;
        e = 3'b101;
`endif
        botao_rst = 1'b1;
        rst_db = 1'b1;
        for (int c = 1; c <= target; c++) begin
            step;
            rst_db = 1'b0;
        end
        tests++;
        if ({sys_rst, factory_rst, busy} !== e) begin
            failed++;
            $display("FAIL async_pre got %b exp %b", {sys_rst, factory_rst, busy}, e);
        end
        #2;
        rst = 1'b1;
        #1;
        exp_cnt = 0;
        tests++;
        if ({sys_rst, factory_rst, busy, rst_count} !== 11'd0) begin
            failed++;
            $display("FAIL async_reset got %b exp %b", {sys_rst, factory_rst, busy, rst_count}, 11'd0);
        end
        step;
        rst = 1'b0;
        botao_rst = 1'b0;
        step;
    endtask
    task automatic test_saturate;
        botao_rst = 1'b0;
        for (int i = 0; i < 300; i++) begin
            rst_db = 1'b1;
            step;
            rst_db = 1'b0;
            repeat (5) step;
            exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
            if (i == 9 || i == 254 || i == 299) begin
                tests++;
                if (rst_count !== 8'(exp_cnt)) begin
                    failed++;
                    $display("FAIL saturate event %0d got %0d exp %0d", i + 1, rst_count, exp_cnt);
                end
            end
        end
    endtask
    initial begin
        test_reset;
        test_soft;
        test_ignore;
        test_back_to_back;
`ifdef RESET_MGR_FACTORY_EN
        test_factory;
        test_hold_abort;
`else
        test_no_factory;
`endif
        test_async_reset;
        test_saturate;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
